// File: rtl/mul_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier that borrows an external
// shared ALU for its additions and left shifts. It produces the low 16 bits of
// the product and a flag that is set when the true product needs more than
// 16 bits.
//
// All outputs are registered, including the ALU drive. The ALU operands for
// the next cycle are derived from the next-state values, so the ALU sees
// stable operands for the whole cycle in which its combinational result is
// consumed.

module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [3:0]  alu_Op,
    output logic        alu_Cin,
    output logic        alu_invA,
    output logic        alu_invB,
    output logic        alu_sign,
    output logic        alu_passthrough,
    output logic        alu_reverse,
    input  logic [15:0] alu_Out,
    input  logic        alu_Ofl
);

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b0010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] acc_r;
    logic [15:0] acc_s;
    logic [15:0] mcand_r;
    logic [15:0] mcand_s;
    logic [15:0] mplier_r;
    logic [15:0] mplier_s;
    logic [4:0]  cnt_r;
    logic [4:0]  cnt_s;
    logic        ovf_acc_r;
    logic        ovf_acc_s;
    logic [15:0] result_s;
    logic        ovf_s;
    logic        busy_s;
    logic        done_s;
    logic [15:0] alu_a_s;
    logic [15:0] alu_b_s;
    logic [3:0]  alu_op_s;

    // The unused ALU controls are held inactive.
    assign alu_Cin         = 1'b0;
    assign alu_invA        = 1'b0;
    assign alu_invB        = 1'b0;
    assign alu_sign        = 1'b0;
    assign alu_passthrough = 1'b0;
    assign alu_reverse     = 1'b0;

    // Next-state and datapath update for one add/shift step of the multiply.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        mcand_s   = mcand_r;
        mplier_s  = mplier_r;
        cnt_s     = cnt_r;
        ovf_acc_s = ovf_acc_r;
        result_s  = result;
        ovf_s     = ovf;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = ADD;
                    acc_s     = 16'h0000;
                    mcand_s   = opA;
                    mplier_s  = opB;
                    cnt_s     = 5'd0;
                    ovf_acc_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                // A carry out of the accumulator only counts when a partial
                // product was actually added.
                acc_s = alu_Out;
                if (mplier_r[0]) begin
                    ovf_acc_s = ovf_acc_r | alu_Ofl;
                end else begin
                    ovf_acc_s = ovf_acc_r;
                end
                state_s = SHIFT;
            end
            SHIFT: begin
                mcand_s  = alu_Out;
                mplier_s = {1'b0, mplier_r[15:1]};
                cnt_s    = cnt_r + 5'd1;
                // Losing a multiplicand bit matters only if a later
                // multiplier bit would still have used it.
                if (mcand_r[15] && (mplier_s != 16'h0000)) begin
                    ovf_acc_s = 1'b1;
                end else begin
                    ovf_acc_s = ovf_acc_r;
                end
                if (cnt_r < 5'd15) begin
                    state_s = ADD;
                end else begin
                    // The result is published as DONE is entered, so it is
                    // already valid in the same cycle as the done pulse.
                    state_s  = DONE;
                    result_s = acc_r;
                    ovf_s    = ovf_acc_s;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values for the state being entered: status flags and ALU drive.
    always_comb begin
        busy_s   = 1'b0;
        done_s   = 1'b0;
        alu_a_s  = 16'h0000;
        alu_b_s  = 16'h0000;
        alu_op_s = OP_ADD;
        case (state_s)
            ADD: begin
                busy_s   = 1'b1;
                alu_op_s = OP_ADD;
                alu_a_s  = acc_s;
                if (mplier_s[0]) begin
                    alu_b_s = mcand_s;
                end else begin
                    alu_b_s = 16'h0000;
                end
            end
            SHIFT: begin
                busy_s   = 1'b1;
                alu_op_s = OP_SLL;
                alu_a_s  = mcand_s;
                alu_b_s  = 16'h0001;
            end
            DONE: begin
                done_s = 1'b1;
            end
            IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            acc_r     <= 16'h0000;
            mcand_r   <= 16'h0000;
            mplier_r  <= 16'h0000;
            cnt_r     <= 5'd0;
            ovf_acc_r <= 1'b0;
            result    <= 16'h0000;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alu_A     <= 16'h0000;
            alu_B     <= 16'h0000;
            alu_Op    <= OP_ADD;
        end else begin
            state_r   <= state_s;
            acc_r     <= acc_s;
            mcand_r   <= mcand_s;
            mplier_r  <= mplier_s;
            cnt_r     <= cnt_s;
            ovf_acc_r <= ovf_acc_s;
            result    <= result_s;
            ovf       <= ovf_s;
            busy      <= busy_s;
            done      <= done_s;
            alu_A     <= alu_a_s;
            alu_B     <= alu_b_s;
            alu_Op    <= alu_op_s;
        end
    end

    mul_seq_checker u_checker (
        .clk    (clk),
        .rst    (rst),
        .busy   (busy),
        .done   (done),
        .alu_Op (alu_Op)
    );

endmodule

// Protocol properties of the multiplier outputs.
module mul_seq_checker (
    input logic       clk,
    input logic       rst,
    input logic       busy,
    input logic       done,
    input logic [3:0] alu_Op
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_done_pulse:     assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_alu_op_legal:   assert property (@(posedge clk) disable iff (rst)
                                       (alu_Op == 4'b1000) || (alu_Op == 4'b0010));

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random checks of mul_seq against a behavioural ALU model.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [3:0]  alu_Op;
    logic        alu_Cin;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic        alu_passthrough;
    logic        alu_reverse;
    logic [15:0] alu_Out;
    logic        alu_Ofl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Combinational ALU: add with carry-out, or logical left shift.
    logic [16:0] alu_sum;
    assign alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
    assign alu_Out = (alu_Op == 4'b0010) ? (alu_A << alu_B[3:0]) : alu_sum[15:0];
    assign alu_Ofl = (alu_Op == 4'b0010) ? 1'b0 : alu_sum[16];

    mul_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .opA             (opA),
        .opB             (opB),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .ovf             (ovf),
        .alu_A           (alu_A),
        .alu_B           (alu_B),
        .alu_Op          (alu_Op),
        .alu_Cin         (alu_Cin),
        .alu_invA        (alu_invA),
        .alu_invB        (alu_invB),
        .alu_sign        (alu_sign),
        .alu_passthrough (alu_passthrough),
        .alu_reverse     (alu_reverse),
        .alu_Out         (alu_Out),
        .alu_Ofl         (alu_Ofl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One multiply, starting on a negedge. Also pokes start mid-run and in
    // DONE, and scrambles the operands after acceptance.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic exp_ovf);
        int          busy_n    = 0;
        int          done_cyc  = -1;
        int          both_bad  = 0;
        int          hold_bad  = 0;
        int          late_busy = 0;
        logic [15:0] res_prev;
        logic [15:0] res_done  = 16'h0000;
        logic        ovf_done  = 1'b0;
        res_prev = result;
        opA   = a;
        opB   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opA   = ~a;
        opB   = b ^ 16'h5A5A;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (busy && done) both_bad++;
            if (done && done_cyc < 0) begin
                done_cyc = c;
                res_done = result;
                ovf_done = ovf;
            end
            if (c < 33 && result !== res_prev) hold_bad++;
            if (c == 35) late_busy = int'(busy);
            if (c == 5 || c == 33) begin
                start = 1'b1;
                opA   = 16'hFFFF;
                opB   = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, ".done_cycle"}, done_cyc, 33);
        chk({tag, ".busy_cycles"}, busy_n, 32);
        chk({tag, ".result"}, res_done, exp_res);
        chk({tag, ".ovf"}, ovf_done, exp_ovf);
        chk({tag, ".busy_and_done"}, both_bad, 0);
        chk({tag, ".result_hold"}, hold_bad, 0);
        chk({tag, ".start_in_done_ignored"}, late_busy, 0);
        chk({tag, ".result_after"}, result, exp_res);
    endtask

    initial begin
        int          dn;
        int          dc [3];
        int          b34;
        int          b68;
        int          res_bad;
        int          busy_n;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] prod;

        rst   = 1'b1;
        start = 1'b1;
        opA   = 16'h1111;
        opB   = 16'h2222;
        repeat (3) @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.result", result, 0);
        chk("reset.ovf", ovf, 0);
        chk("reset.alu_Op", alu_Op, 32'h8);
        chk("reset.alu_A", alu_A, 0);
        chk("reset.alu_B", alu_B, 0);
        chk("ties", {alu_Cin, alu_invA, alu_invB, alu_sign, alu_passthrough, alu_reverse}, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle.busy", busy, 0);

        run_mul("m3x5", 16'd3, 16'd5, 16'd15, 1'b0);
        run_mul("m0xFFFF", 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
        run_mul("m1234x1", 16'h1234, 16'h0001, 16'h1234, 1'b0);

        // Start held high: a new multiply every 34 cycles, none taken in DONE.
        dn      = 0;
        b34     = -1;
        b68     = -1;
        res_bad = 0;
        busy_n  = 0;
        opA     = 16'd7;
        opB     = 16'd9;
        start   = 1'b1;
        for (int c = 1; c <= 102; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                if (dn < 3) dc[dn] = c;
                dn++;
                if (result !== 16'd63) res_bad++;
            end
            if (c == 34) b34 = int'(busy);
            if (c == 68) b68 = int'(busy);
            if (c == 101) start = 1'b0;
        end
        chk("cont.done_count", dn, 3);
        chk("cont.done0", dc[0], 33);
        chk("cont.done1", dc[1], 67);
        chk("cont.done2", dc[2], 101);
        chk("cont.idle34", b34, 0);
        chk("cont.idle68", b68, 0);
        chk("cont.busy_cycles", busy_n, 96);
        chk("cont.result", res_bad, 0);
        chk("cont.ovf", ovf, 0);
        chk("cont.stopped", busy, 0);

        run_mul("mFFFFx2", 16'hFFFF, 16'h0002, 16'hFFFE, 1'b1);

        // Reset in the middle of a multiply.
        opA   = 16'd3;
        opB   = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.result", result, 0);
        chk("midrst.ovf", ovf, 0);
        chk("midrst.alu_A", alu_A, 0);
        rst   = 1'b0;
        start = 1'b0;
        run_mul("m0100x0100", 16'h0100, 16'h0100, 16'h0000, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            if (i % 8 == 1) ra = 16'($urandom_range(0, 255));
            if (i % 8 == 2) rb = 16'($urandom_range(0, 255));
            prod = {16'h0000, ra} * {16'h0000, rb};
            run_mul("rand", ra, rb, prod[15:0], prod > 32'h0000FFFF);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; ports and widths are REQ-002..REQ-014.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  Synchronous active-high reset.
REQ-004 start  input  1  Request a multiply; sampled only in IDLE.
REQ-005 opA, opB  input  16 each  Multiplicand and multiplier; captured on an accepted start.
REQ-006 busy  output  1  High while a multiply is in progress.
REQ-007 done  output  1  One-cycle pulse when result becomes valid.
REQ-008 result  output  16  Low 16 bits of unsigned opA*opB; held until the next accepted start.
REQ-009 ovf  output  1  Sticky unsigned overflow for the current result.
REQ-010 alu_A, alu_B  output  16 each  Operands to the shared ALU.
REQ-011 alu_Op  output  4  ALU opcode: 4'b1000 add, 4'b0010 shift-left-logical.
REQ-012 alu_Cin, alu_invA, alu_invB, alu_sign, alu_passthrough, alu_reverse  output  1 each  Tied 0.
REQ-013 alu_Out  input  16  Combinational ALU result, same cycle.
REQ-014 alu_Ofl  input  1  ALU unsigned carry-out flag (valid for add).

Function
REQ-015 States SHALL be IDLE, ADD, SHIFT, DONE; internal regs acc[15:0], mcand[15:0], mplier[15:0], cnt[4:0].
REQ-016 IDLE: start=1 SHALL load acc=0, mcand=opA, mplier=opB, cnt=0, clear ovf, go to ADD; start=0 stays IDLE.
REQ-017 ADD: alu_Op=1000, alu_A=acc, alu_B = mplier[0] ? mcand : 16'h0000; acc SHALL load alu_Out; ovf SHALL OR in alu_Ofl when mplier[0]=1; next SHIFT.
REQ-018 SHIFT: alu_Op=0010, alu_A=mcand, alu_B=16'h0001; mcand SHALL load alu_Out; mplier SHALL shift right by 1 (zero fill); cnt increments.
REQ-019 SHIFT with mcand[15]=1 and (mplier>>1)!=0 SHALL set ovf.
REQ-020 SHIFT transitions to ADD when cnt<15, else to DONE (exactly 16 ADD/SHIFT pairs).
REQ-021 DONE: result SHALL load acc, done=1 for this cycle only, next IDLE.
REQ-022 Latency: start accepted at cycle 0 -> busy high cycles 1..32 -> done and new result at cycle 33; next start accepted at cycle 34 earliest.
REQ-023 busy SHALL be 1 in ADD and SHIFT, 0 in IDLE and DONE; done and busy never both 1.
REQ-024 start while busy or in DONE SHALL be ignored with no effect on state, result or ovf.
REQ-025 In IDLE and DONE, alu_Op=1000, alu_A=alu_B=0 (ALU drive is deterministic, never X).
REQ-026 opA/opB changes after the start cycle SHALL NOT affect the in-flight result.
REQ-027 result and ovf SHALL change only in DONE (ovf internal accumulator copied with result) and on reset.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, ovf=0, acc=mcand=mplier=0, cnt=0, from any state.
REQ-029 Reset mid-operation SHALL abort with no done pulse; reset has priority over start in the same cycle.

Verification
REQ-030 Bench SHALL model the ALU combinationally (add, SLL) behind alu_* ports.
REQ-031 opA=3, opB=5, start 1 cycle -> done at cycle 33, result=15, ovf=0, busy high exactly 32 cycles.
REQ-032 opA=16'hFFFF, opB=16'h0002 -> result=16'hFFFE, ovf=1; then opA=16'h0100, opB=16'h0100 -> result=0, ovf=1.
REQ-033 opA=0, opB=16'hFFFF and opA=16'h1234, opB=1 -> results 0 and 16'h1234, ovf=0 both.
REQ-034 start held high continuously with opA=7, opB=9 -> done every 34 cycles, result=63, no start accepted while busy or in DONE.
REQ-035 rst asserted at cycle 10 of a multiply -> next cycle busy=0, result=0, ovf=0, no done pulse; start on the cycle after reset release works normally.
REQ-036 Random opA/opB (>=1000 pairs) -> result equals (opA*opB) mod 2^16, ovf equals (opA*opB) >= 2^16.
